// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32 load/store funct3 size codes and LSU FSM state encoding.
// No ports; imported by lsu_data_mem.
package riscv_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: DEPTH_WORDS x 32 storage, per-byte write enables, combinational read.
// Ports: clk; addr_i word index; be_i byte-lane write enables; wdata_i lane-replicated
// write data; rdata_o word at addr_i.
module dmem_ram #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [3:0]                     be_i,
  input  logic [31:0]                    wdata_i,
  output logic [31:0]                    rdata_o
);
  logic [31:0] r_mem [DEPTH_WORDS];
  always_ff @(posedge clk)
    for (int b = 0; b < 4; b++)
      if (be_i[b]) r_mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
  assign rdata_o = r_mem[addr_i];
endmodule

// File: rtl/lsu_data_mem.sv
// lsu_data_mem: multi-cycle RV32 data memory with lane merge, sign extension and fault decode.
// Ports: clk, rst (async active-high); req_i/we_i/size_i/addr_i/wdata_i request;
// rdata_o registered load result; done_o completion pulse; fault_o access error
// (valid with done_o); stall_o CPU stall request.
module lsu_data_mem
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        fault_o,
  output logic        stall_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [2:0]  r_size;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic        r_fault;
  logic        w_access, w_fault, w_size_ok;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_rword, w_shift, w_load;
  logic [15:0] w_half;
  assign w_access  = (r_state == BUSY) && (r_cnt == 4'd0);
  assign w_size_ok = (r_size == F3_B || r_size == F3_H || r_size == F3_W ||
                      r_size == F3_BU || r_size == F3_HU) && !(r_we && r_size[2]);
  // Upper address bits above the array span flag an out-of-range access.
  assign w_fault = !w_size_ok ||
                   (r_size[1:0] == 2'b01 && r_addr[0]) ||
                   (r_size[1:0] == 2'b10 && r_addr[1:0] != 2'b00) ||
                   (|r_addr[31:AW+2]);
  // Store data is replicated across lanes so the byte enables alone pick the target lanes.
  always_comb begin
    w_wdata = r_size[1:0] == 2'b00 ? {4{r_wdata[7:0]}} :
              r_size[1:0] == 2'b01 ? {2{r_wdata[15:0]}} : r_wdata;
    w_be    = r_size[1:0] == 2'b00 ? 4'b0001 << r_addr[1:0] :
              r_size[1:0] == 2'b01 ? (r_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    w_be    = (w_access && r_we && !w_fault) ? w_be : 4'b0000;
  end
  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk    (clk),
    .addr_i (r_addr[AW+1:2]),
    .be_i   (w_be),
    .wdata_i(w_wdata),
    .rdata_o(w_rword)
  );
  assign w_shift = w_rword >> {r_addr[1:0], 3'b000};
  assign w_half  = r_addr[1] ? w_rword[31:16] : w_rword[15:0];
  assign w_load  = r_size[1:0] == 2'b10 ? w_rword :
                   r_size[1:0] == 2'b01 ? {{16{~r_size[2] & w_half[15]}}, w_half} :
                   {{24{~r_size[2] & w_shift[7]}}, w_shift[7:0]};
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = req_i ? BUSY : IDLE;
      BUSY:    w_next = r_cnt == 4'd0 ? DONE : BUSY;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 32'd0;
      r_fault <= 1'b0;
      r_we    <= 1'b0;
      r_size  <= 3'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else begin
      r_state <= w_next;
      r_fault <= w_access && w_fault;
      if (r_state == IDLE && req_i) begin
        r_cnt   <= 4'(WAIT_STATES);
        r_we    <= we_i;
        r_size  <= size_i;
        r_addr  <= addr_i;
        r_wdata <= wdata_i;
      end else if (r_state == BUSY && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      if (w_access) r_rdata <= (r_we || w_fault) ? 32'd0 : w_load;
    end
  assign rdata_o = r_rdata;
  assign done_o  = r_state == DONE;
  assign fault_o = r_fault;
  assign stall_o = req_i && !done_o;
endmodule

// File: tb/tb_lsu_data_mem.sv
// tb_lsu_data_mem: directed vector bench for lsu_data_mem (WAIT_STATES 0 and 3).
module tb_lsu_data_mem;
  import riscv_pkg::*;
  logic        clk = 0, rst = 1, req0 = 0, req1 = 0, we_i = 0;
  logic [2:0]  size_i = 0;
  logic [31:0] addr_i = 0, wdata_i = 0;
  logic [31:0] rdata0, rdata1;
  logic        done0, done1, fault0, fault1, stall0, stall1;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  lsu_data_mem #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req_i(req0), .we_i(we_i), .size_i(size_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata0), .done_o(done0), .fault_o(fault0), .stall_o(stall0));
  lsu_data_mem #(.DEPTH_WORDS(256), .WAIT_STATES(3)) dut1 (
    .clk(clk), .rst(rst), .req_i(req1), .we_i(we_i), .size_i(size_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata1), .done_o(done1), .fault_o(fault1), .stall_o(stall1));
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic access(input int d, input logic we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic ef,
                        input bit pert, input string nm);
    int lat;
    logic [31:0] rd;
    logic dn, ft, st;
    @(negedge clk);
    we_i = we; size_i = sz; addr_i = a; wdata_i = wd;
    if (d == 0) req0 = 1; else req1 = 1;
    @(posedge clk);
    lat = -1; rd = 'x; ft = 'x;
    for (int c = 0; c < 40; c++) begin
      #1;
      dn = d != 0 ? done1 : done0;
      st = d != 0 ? stall1 : stall0;
      ft = d != 0 ? fault1 : fault0;
      if (dn) begin
        lat = c;
        rd  = d != 0 ? rdata1 : rdata0;
        chk({nm, " stall@done"}, 32'(st), 32'd0);
        break;
      end
      chk($sformatf("%s stall@c%0d", nm, c), 32'(st), 32'd1);
      chk($sformatf("%s fault-no-done@c%0d", nm, c), 32'(ft), 32'd0);
      if (pert && c == 2) begin
        addr_i = a ^ 32'h4; wdata_i = ~wd;
      end
      @(posedge clk);
    end
    req0 = 0; req1 = 0;
    chk({nm, " latency"}, 32'(lat), d != 0 ? 32'd4 : 32'd1);
    chk({nm, " rdata"}, rd, er);
    chk({nm, " fault"}, 32'(ft), 32'(ef));
    @(posedge clk);
  endtask
  typedef struct {
    logic        we;
    logic [2:0]  sz;
    logic [31:0] a, wd, er;
    logic        ef;
  } vec_t;
  vec_t v[$];
  initial begin
    v.push_back('{1, F3_W,  32'h10,  32'hDEADBEEF, 32'h0,        0});
    v.push_back('{0, F3_W,  32'h10,  32'h0,        32'hDEADBEEF, 0});
    v.push_back('{1, F3_W,  32'h10,  32'h11223344, 32'h0,        0});
    v.push_back('{1, F3_B,  32'h13,  32'h123456AA, 32'h0,        0});
    v.push_back('{0, F3_W,  32'h10,  32'h0,        32'hAA223344, 0});
    v.push_back('{0, F3_B,  32'h13,  32'h0,        32'hFFFFFFAA, 0});
    v.push_back('{0, F3_BU, 32'h13,  32'h0,        32'h000000AA, 0});
    v.push_back('{0, F3_H,  32'h12,  32'h0,        32'hFFFFAA22, 0});
    v.push_back('{0, F3_HU, 32'h12,  32'h0,        32'h0000AA22, 0});
    v.push_back('{0, F3_B,  32'h10,  32'h0,        32'h00000044, 0});
    v.push_back('{0, F3_H,  32'h10,  32'h0,        32'h00003344, 0});
    v.push_back('{1, F3_H,  32'h12,  32'h9999BEEF, 32'h0,        0});
    v.push_back('{0, F3_W,  32'h10,  32'h0,        32'hBEEF3344, 0});
    v.push_back('{0, F3_H,  32'h11,  32'h0,        32'h0,        1});
    v.push_back('{0, F3_W,  32'h10,  32'h0,        32'hBEEF3344, 0});
    v.push_back('{1, F3_W,  32'h12,  32'h55555555, 32'h0,        1});
    v.push_back('{0, F3_W,  32'h10,  32'h0,        32'hBEEF3344, 0});
    v.push_back('{1, F3_W,  32'h400, 32'h66666666, 32'h0,        1});
    v.push_back('{0, F3_W,  32'h10,  32'h0,        32'hBEEF3344, 0});
    v.push_back('{0, 3'b011, 32'h10, 32'h0,        32'h0,        1});
    v.push_back('{0, F3_W,  32'h10,  32'h0,        32'hBEEF3344, 0});
    v.push_back('{1, F3_BU, 32'h10,  32'h77777777, 32'h0,        1});
    v.push_back('{0, F3_W,  32'h10,  32'h0,        32'hBEEF3344, 0});
    v.push_back('{1, F3_W,  32'h3FC, 32'h0BADF00D, 32'h0,        0});
    v.push_back('{0, F3_W,  32'h3FC, 32'h0,        32'h0BADF00D, 0});
    v.push_back('{0, F3_B,  32'h400, 32'h0,        32'h0,        1});
    v.push_back('{0, 3'b111, 32'h3FC, 32'h0,       32'h0,        1});
    req0 = 1; req1 = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst done0", 32'(done0), 32'd0);
    chk("rst fault0", 32'(fault0), 32'd0);
    chk("rst rdata0", rdata0, 32'd0);
    chk("rst stall0", 32'(stall0), 32'd1);
    chk("rst done1", 32'(done1), 32'd0);
    chk("rst stall1", 32'(stall1), 32'd1);
    req1 = 0;
    rst = 0;
    foreach (v[i]) access(0, v[i].we, v[i].sz, v[i].a, v[i].wd, v[i].er, v[i].ef, 0,
                          $sformatf("v%0d", i));
    access(1, 1, F3_W, 32'h34, 32'hCAFEF00D, 32'h0, 0, 0, "ws_init34");
    access(1, 1, F3_W, 32'h30, 32'h12345678, 32'h0, 0, 1, "ws_store_pert");
    access(1, 0, F3_W, 32'h30, 32'h0, 32'h12345678, 0, 0, "ws_load30");
    access(1, 0, F3_W, 32'h34, 32'h0, 32'hCAFEF00D, 0, 0, "ws_load34");
    access(1, 0, F3_H, 32'h31, 32'h0, 32'h0, 1, 0, "ws_fault");
    access(1, 1, F3_W, 32'h20, 32'h0, 32'h0, 0, 0, "mid_init");
    access(1, 0, F3_W, 32'h30, 32'h0, 32'h12345678, 0, 0, "mid_preload");
    @(negedge clk);
    we_i = 1; size_i = F3_W; addr_i = 32'h20; wdata_i = 32'h55; req1 = 1;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1;
    #2;
    chk("mid rst done1", 32'(done1), 32'd0);
    chk("mid rst fault1", 32'(fault1), 32'd0);
    chk("mid rst rdata1", rdata1, 32'd0);
    req1 = 0;
    rst = 0;
    access(1, 0, F3_W, 32'h20, 32'h0, 32'h0, 0, 0, "mid_load20");
    access(0, 0, F3_W, 32'h10, 32'h0, 32'hBEEF3344, 0, 0, "post_rst_keep");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lsu_data_mem.md
LSU_DATA_MEM -- requirements
Module: lsu_data_mem

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, SHALL set the number of 32-bit words in the array; legal values are powers of two from 4 to 65536.
REQ-002 Parameter WAIT_STATES, default 0, SHALL set the number of extra busy cycles per access; legal range is 0..15.
REQ-003 The clock and reset SHALL be one clock and an asynchronous, active-high reset: clk in 1 (rising-edge clock), rst in 1 (asynchronous, active-high reset).
REQ-004 The ports SHALL be (name, direction, width, meaning):
- req_i in 1: access request.
- we_i in 1: 1 = store, 0 = load.
- size_i in 3: RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- addr_i in 32: byte address.
- wdata_i in 32: store data, right-aligned.
- rdata_o out 32: load result.
- done_o out 1: one-cycle completion pulse.
- fault_o out 1: access error, valid with done_o.
- stall_o out 1: CPU stall request.

Function
REQ-005 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-006 In IDLE with req_i=1, the rising edge SHALL latch we_i, size_i, addr_i and wdata_i, load the counter with WAIT_STATES, and enter BUSY.
REQ-007 In BUSY, if counter≠0 the counter SHALL decrement; if counter=0 the edge SHALL perform the access and enter DONE.
REQ-008 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE.
REQ-009 Requests SHALL be accepted only in IDLE; input changes during BUSY or DONE SHALL have no effect.
REQ-010 Latency SHALL be fixed: done_o is high in cycle WAIT_STATES+1 after the accept cycle (cycle 0).
REQ-011 Back-to-back throughput SHALL be one access per WAIT_STATES+3 cycles.
REQ-012 stall_o SHALL be the combinational value req_i AND NOT done_o.
REQ-013 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; byte lane SHALL be addr[1:0].
REQ-014 A store SHALL write only the addressed lanes: SB writes wdata[7:0] to lane addr[1:0]; SH writes wdata[15:0] to lanes {addr[1],0} and {addr[1],1}; SW writes all four lanes.
REQ-015 Loads SHALL extract the addressed byte or halfword: LB and LH sign-extend, LBU and LHU zero-extend, LW returns the full word.
REQ-016 rdata_o SHALL be registered on the access edge and held until the next access edge.
REQ-017 rdata_o SHALL be 0 after any store and after any faulted access.
REQ-018 An access SHALL fault when any of the following holds:
- halfword access with addr[0]=1;
- word access with addr[1:0]≠0;
- addr ≥ 4·DEPTH_WORDS;
- illegal size (011, 110, 111, or a store with size_i[2]=1).
REQ-019 A faulted access SHALL leave memory unchanged, set fault_o=1 during DONE, and keep the same latency as a non-faulted access.
REQ-020 fault_o SHALL be 0 whenever done_o=0.
REQ-021 A store followed by a load to the same address SHALL return the new data; there is no hazard window.

Reset
REQ-022 When rst is asserted, the block SHALL asynchronously force state=IDLE, counter=0, done_o=0, fault_o=0 and rdata_o=0.
REQ-023 Reset during BUSY SHALL discard the pending access; a pending store SHALL NOT be written.
REQ-024 Array contents SHALL NOT be reset.
REQ-025 The first request SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-026 Package riscv_pkg SHALL hold the funct3 load/store size constants and the FSM state encoding.
REQ-027 Sub-module dmem_ram SHALL hold the storage: DEPTH_WORDS×32 array, 4 byte-write enables, combinational read port, write on clk.
REQ-028 Lane merge, sign extension, fault decode, FSM and counter SHALL reside in lsu_data_mem.

Verification
REQ-029 Reset: with rst=1 and req_i=1, the bench SHALL check done_o=0, fault_o=0, rdata_o=0 and stall_o=1.
REQ-030 Word round-trip (W=0): SW 0xDEADBEEF to 0x10, then LW 0x10, SHALL return 0xDEADBEEF with done_o in cycle 1 after accept and stall_o high in cycle 0 only.
REQ-031 Lanes: word 0x11223344 at 0x10, then SB 0xAA to 0x13, SHALL give:
- LW 0x10 → 0xAA223344;
- LB 0x13 → 0xFFFFFFAA;
- LBU 0x13 → 0x000000AA;
- LH 0x12 → 0xFFFFAA22.
REQ-032 Faults: each of the following SHALL give fault_o=1 with done_o and rdata_o=0, and a subsequent LW SHALL show memory unchanged:
- LH at 0x11;
- SW at 0x12;
- SW at 0x400 (DEPTH_WORDS=256);
- size_i=011.
REQ-033 Wait states: with WAIT_STATES=3, done_o SHALL occur in cycle 4 after accept and stall_o SHALL be high in cycles 0-3; addr_i and wdata_i changed in cycle 2 SHALL be ignored.
REQ-034 Reset mid-store: rst pulsed during BUSY of SW 0x55 to 0x20 (old value 0x0) SHALL be followed by LW 0x20 returning 0x0.
